// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Rounded clock-cycles per oversample tick.
  function automatic int uart_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE));
  endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// rtl/uart_rx_fifo_buf.sv - first-word-fall-through FIFO; a pop frees space for a same-cycle push.
module uart_rx_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling 8N1 deframer feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int DIV = uart_div(longint'(CLK_HZ), longint'(BAUD));
  localparam int DW  = $clog2(DIV + 1);

  rx_state_t     state_q, state_d;
  logic          rx_meta, rx_s, rx_prev;
  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          tick, mid, clr_cnt, shift_en, push_d, ferr_d, push_q;
  logic          full, empty, pop;
`ifdef UART_RX_PARITY_EN
  logic          par_sample, par_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Every sample point is tick_cnt == MID_TICK; the 4-bit counter wraps each bit.
  assign tick = (div_cnt == DW'(DIV - 1));
  assign mid  = tick && (tick_cnt == 4'(MID_TICK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    push_d   = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state_q)
      IDLE:  if (!rx_s && rx_prev) begin
               clr_cnt = 1'b1;
               state_d = START;
             end
      START: if (mid) state_d = rx_s ? IDLE : DATA;
      DATA:  if (mid) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == 3'd7) state_d = PARITY;
`else
               if (bit_cnt == 3'd7) state_d = STOP;
`endif
             end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
                par_sample = 1'b1;
                state_d    = STOP;
              end
`endif
      STOP:  if (mid) begin
               if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                 push_d = ~par_bad;
`else
                 push_d = 1'b1;
`endif
                 state_d = IDLE;
               end else begin
                 ferr_d  = 1'b1;
                 state_d = BREAK;
               end
             end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else if (clr_cnt) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      push_q    <= push_d;
      frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      parity_err <= mid && (state_q == STOP) && par_bad;
      if (par_sample) par_bad <= (rx_s != ^shift_q);
`endif
    end
  end

  // shift_q is stable while push_q is high: the FSM is back in IDLE by then.
  uart_rx_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign overrun  = push_q & full & ~pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo (4 clocks per tick, 64 clocks per bit).
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 7_372_800;
  localparam int BAUD   = 115_200;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] level;
  logic       frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, valid_cyc = 0;
  int bit_clks = 64;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .level     (level),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    if (rd_valid) valid_cyc++;
    if (rd_valid && rd_ready) rx_q.push_back(rd_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par = 1'b0,
                           input logic stop = 1'b1, input int stop_bits = 1);
    rx = 1'b0;
    cyc(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(bit_clks);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    cyc(bit_clks);
`else
    if (bad_par) cyc(0);
`endif
    rx = stop;
    cyc(bit_clks * stop_bits);
    rx = 1'b1;
    cyc(bit_clks);
  endtask

  initial begin
    int s, f, o, v, p;

    cyc(3);
    check("rst_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    cyc(10);

    // single byte
    rd_ready = 1'b1;
    s = rx_q.size(); f = ferr_cnt; o = ovr_cnt; v = valid_cyc;
    send_byte(8'hA5);
    check("a5_count", rx_q.size() - s, 1);
    check("a5_data", rx_q[s], 8'hA5);
    check("a5_valid_cycles", valid_cyc - v, 1);
    check("a5_ferr", ferr_cnt - f, 0);
    check("a5_ovr", ovr_cnt - o, 0);
    check("a5_level", level, 0);

    // start glitch of 4 ticks
    s = rx_q.size(); f = ferr_cnt;
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(bit_clks * 2);
    check("glitch_count", rx_q.size() - s, 0);
    check("glitch_ferr", ferr_cnt - f, 0);
    send_byte(8'h3C);
    check("after_glitch_count", rx_q.size() - s, 1);
    check("after_glitch_data", rx_q[s], 8'h3C);

    // framing error with line held low for two bit times
    s = rx_q.size(); f = ferr_cnt;
    send_byte(8'h55, 1'b0, 1'b0, 2);
    check("ferr_pulses", ferr_cnt - f, 1);
    check("ferr_level", level, 0);
    check("ferr_count", rx_q.size() - s, 0);
    send_byte(8'h81);
    check("after_ferr_data", rx_q[s], 8'h81);
    check("after_ferr_pulses", ferr_cnt - f, 1);

    // baud mismatch of about +-1.6 %
    s = rx_q.size();
    bit_clks = 63;
    send_byte(8'h96);
    bit_clks = 65;
    send_byte(8'h69);
    bit_clks = 64;
    check("fast_data", rx_q[s], 8'h96);
    check("slow_data", rx_q[s+1], 8'h69);

    // overrun on the 17th byte
    rd_ready = 1'b0;
    cyc(4);
    s = rx_q.size(); o = ovr_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("fill_level", level, 16);
    check("fill_ovr", ovr_cnt - o, 0);
    check("fill_head", rd_data, 8'h00);
    send_byte(8'h10);
    check("ovr_level", level, 16);
    check("ovr_pulses", ovr_cnt - o, 1);
    rd_ready = 1'b1;
    cyc(24);
    check("drain_count", rx_q.size() - s, 16);
    for (int i = 0; i < 16; i++) check($sformatf("drain_%0d", i), rx_q[s+i], 8'(i));
    check("drain_level", level, 0);
    check("drain_valid", rd_valid, 0);

    // reset during data bit 4 with a byte already buffered
    rd_ready = 1'b0;
    send_byte(8'h11);
    check("pre_rst_level", level, 1);
    rx = 1'b0;
    cyc(bit_clks);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      cyc(bit_clks);
    end
    rx = 1'b1;
    cyc(20);
    rst = 1'b1;
    #1;
    check("midrst_valid", rd_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_data", rd_data, 8'h00);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    cyc(3);
    rst = 1'b0;
    cyc(bit_clks * 8);
    check("post_rst_level", level, 0);
    rd_ready = 1'b1;
    s = rx_q.size(); f = ferr_cnt;
    send_byte(8'hF0);
    check("post_rst_count", rx_q.size() - s, 1);
    check("post_rst_data", rx_q[s], 8'hF0);
    check("post_rst_ferr", ferr_cnt - f, 0);

`ifdef UART_RX_PARITY_EN
    s = rx_q.size(); p = perr_cnt; f = ferr_cnt;
    send_byte(8'h07, 1'b1);
    check("par_bad_pulses", perr_cnt - p, 1);
    check("par_bad_count", rx_q.size() - s, 0);
    check("par_bad_ferr", ferr_cnt - f, 0);
    send_byte(8'h07, 1'b0);
    check("par_ok_pulses", perr_cnt - p, 1);
    check("par_ok_data", rx_q[s], 8'h07);
`else
    p = perr_cnt;
    check("no_parity_pulses", perr_cnt - p, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

RS-232 receive front end that sits between the board `rx` pin and a byte-stream consumer: the soft-core UART or a standalone command decoder. It synchronises the asynchronous serial line, oversamples it 16×, deframes 8N1 characters LSB-first, and buffers the received bytes in a first-word-fall-through FIFO. The FIFO exposes a valid/ready read port. Framing and overrun errors are flagged as one-cycle pulses.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `FIFO_DEPTH`, 16: number of FIFO entries; must be a power of 2, ≥ 2.
- `clk`, in, 1: single system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial line, asynchronous to `clk`, idle high.
- `rd_data`, out, 8: head-of-FIFO byte; valid only while `rd_valid` = 1.
- `rd_valid`, out, 1: FIFO not empty.
- `rd_ready`, in, 1: consumer accepts the byte; a pop occurs when `rd_valid & rd_ready`.
- `level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun`, out, 1: one-cycle pulse when a byte is dropped because the FIFO is full.

## Operation
- **Synchroniser:** 2-flop synchroniser on `rx`; both flops reset to 1.
- **Tick generator:**
  - `DIV = round(CLK_HZ / (BAUD*16))`, which is 27 at the defaults; counts 0..DIV-1.
  - `tick` is asserted when the count equals DIV-1.
  - The counter is cleared when a start edge is detected in IDLE, so sampling is phase-aligned to the frame.
- **Receive FSM** (`rx_s` below is the synchronised `rx`):
  - IDLE: waits for `rx_s` = 0 (falling edge relative to the previous sample). On detection, clears the tick and bit counters and goes to START.
  - START: at the 8th tick (mid-bit), samples `rx_s`. If 0 → DATA. If 1 → IDLE, treated as a glitch with no output and no error.
  - DATA: samples every 16 ticks, 8 bits, shifted in LSB first. After bit 7 → STOP (or PARITY when enabled).
  - STOP: samples at mid-bit.
    - If 1: push the byte, then → IDLE.
    - If 0: pulse `frame_err`, discard the byte, then go to BREAK.
  - BREAK: waits for `rx_s` = 1, then → IDLE. This prevents a held-low line from retriggering the FSM.
- **FIFO:**
  - Circular buffer with wrap-around read and write pointers, one bit wider than the address, so that full and empty are distinguishable.
  - Push while full: the byte is dropped, `overrun` pulses, and the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop is performed first and the push is accepted, so `level` stays at DEPTH and `overrun` does not pulse.
  - Push and pop in the same cycle while empty: not possible, because `rd_valid` is 0.
  - Ordering is strictly first-in, first-out.
- **Reset** (including mid-frame):
  - FSM → IDLE; pointers and `level` → 0.
  - `rd_valid`, `frame_err`, `overrun` → 0; `rd_data` → 0x00.
  - Any partially received byte is lost.

## Timing
- **Input latency:** 2 cycles from the `rx` pin to `rx_s`.
- **Push:** the FIFO write is registered in the cycle after the stop-bit mid-sample.
- **Read availability:** `rd_valid` rises 1 cycle after a write into an empty FIFO, with `rd_data` valid in the same cycle.
- **Pop:** `rd_data` and `rd_valid` update in the cycle after `rd_valid & rd_ready`. With `rd_ready` held high, one byte is popped per cycle.
- **Error pulses:**
  - `frame_err` is asserted in the cycle after the stop sample.
  - `overrun` is asserted in the cycle of the rejected push.
- **Clock tolerance:** the receiver must tolerate ±2 % baud mismatch, because sampling is mid-bit with 16× resolution.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined:** frame format is 8E1. A PARITY state follows DATA and samples one bit. If the received parity is wrong, the byte is discarded and a one-cycle `parity_err` output pulses in the same cycle position as `frame_err`. If parity and stop bit are both bad, both pulses are asserted.
  - **Undefined:** frame format is 8N1, and the PARITY state and the `parity_err` port do not exist.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - `OVERSAMPLE = 16`; `MID_TICK = 7`.
  - A function computing DIV from CLK_HZ and BAUD.
- **Sub-module `uart_rx_fifo_buf`:** parameterised FWFT FIFO (push, pop, data, full, empty, level), instantiated once. The deframer stays in the top of `uart_rx_fifo`.

## Test plan
- **Single byte:** drive 0xA5 at 115200 baud with `rd_ready` = 1 → `rd_data` = 0xA5 for exactly one cycle of `rd_valid`; no error pulses.
- **Start glitch:** drive a 4-tick low pulse on an idle line → no push, no error, FSM back in IDLE; a subsequent 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit forced to 0, held low for 2 bit-times, then idle → one `frame_err` pulse, `level` = 0. A following 0x81 is received.
- **Overrun:** send 17 bytes 0x00..0x10 with `rd_ready` = 0 → `level` = 16 and one `overrun` pulse on the 17th byte. Draining yields 0x00..0x0F in order.
- **Reset mid-frame:** assert `rst` during data bit 4 → all outputs 0 and FIFO empty. After release, a full 0xF0 frame is received correctly.
- **Parity (`UART_RX_PARITY_EN` defined):** send 0x07 with odd parity → one `parity_err` pulse, no push. Send 0x07 with even parity → byte delivered.
